lsu_mem_stage: RTL and testbench

//  M-stage load/store unit, directly downstream of the X/M datapath registers.
//  - Takes the registered ALU result as the effective address.
//  - Runs one data-memory transaction per load/store over a req/gnt/rvalid bus.
//  - Stalls the pipeline until the response arrives.
//  - Returns aligned, sign/zero-extended load data to the W-stage writeback mux.

---
 rtl/proc_pkg.sv | 34 +++
 rtl/lsu_align.sv | 45 ++++
 rtl/lsu_mem_stage.sv | 174 +++++++++++++++++
 tb/tb_lsu_mem_stage.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared processor types used by the load/store unit.
package proc_pkg;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } mem_op_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } lsu_state_t;

  // Halves need an even address; words (and any unknown size) need a word-aligned address.
  function automatic logic is_misaligned(mem_size_t size, logic [1:0] offset);
    logic mis;
    mis = 1'b0;
    if (size == SZ_HALF) begin
      mis = offset[0];
    end else if (size != SZ_BYTE) begin
      mis = (offset != 2'b00);
    end
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: byte enables and replicated store data on the way out,
// shifted and extended load data on the way back.
module lsu_align
  import proc_pkg::*;
(
  input  mem_size_t   size,
  input  logic        is_unsigned,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  // Bring the addressed byte/half down to bit 0 before extension.
  assign shifted = rdata >> {offset, 3'b000};

  // Per-size enables, store replication and load extension.
  always_comb begin
    be        = 4'b1111;
    wdata     = store_data;
    load_data = shifted;
    case (size)
      SZ_BYTE: begin
        be        = 4'b0001 << offset;
        wdata     = {4{store_data[7:0]}};
        load_data = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        be        = 4'b0011 << {offset[1], 1'b0};
        wdata     = {2{store_data[15:0]}};
        load_data = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
      end
      default: begin
        be        = 4'b1111;
        wdata     = store_data;
        load_data = shifted;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// M-stage load/store unit: one req/gnt/rvalid transaction per memory op, pipeline stall
// until the response, aligned and extended load data handed to W.
module lsu_mem_stage
  import proc_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              m_valid_i,
  input  mem_op_t           m_mem_op_i,
  input  mem_size_t         m_mem_size_i,
  input  logic              m_mem_unsigned_i,
  input  logic [31:0]       m_alu_data_i,
  input  logic [DATA_W-1:0] m_store_data_i,
  input  logic              flush_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [3:0]        dmem_be_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [DATA_W-1:0] dmem_rdata_i,
  output logic              stall_o,
  output logic              misalign_o,
  output logic              w_load_valid_o,
  output logic [DATA_W-1:0] w_load_data_o
);

  lsu_state_t  state_q, state_d;
  logic        abort_q, abort_d;

  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic              we_q;
  mem_size_t         size_q;
  logic              unsigned_q;
  logic [1:0]        offset_q;
  logic              misalign_q;
  logic              load_valid_q;
  logic [31:0]       load_data_q;

  logic        mem_op;
  logic        misaligned;
  logic        accept;
  logic        stall;
  logic        load_fire;

  mem_size_t   al_size;
  logic        al_unsigned;
  logic [1:0]  al_offset;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_load;

  assign mem_op     = m_valid_i && (m_mem_op_i != MEM_NONE);
  assign misaligned = is_misaligned(m_mem_size_i, m_alu_data_i[1:0]);
  assign accept     = (state_q == IDLE) && mem_op && !misaligned && !flush_i;

  // In IDLE the aligner sees the incoming op (for be/wdata capture); otherwise it sees the
  // captured op so the response is extracted with the right size and offset.
  always_comb begin
    al_size     = size_q;
    al_unsigned = unsigned_q;
    al_offset   = offset_q;
    if (state_q == IDLE) begin
      al_size     = m_mem_size_i;
      al_unsigned = m_mem_unsigned_i;
      al_offset   = m_alu_data_i[1:0];
    end
  end

  lsu_align u_align (
    .size        (al_size),
    .is_unsigned (al_unsigned),
    .offset      (al_offset),
    .store_data  (m_store_data_i),
    .rdata       (dmem_rdata_i),
    .be          (al_be),
    .wdata       (al_wdata),
    .load_data   (al_load)
  );

  // Next state, abort tracking, stall and load-complete strobe.
  always_comb begin
    state_d   = state_q;
    abort_d   = abort_q;
    stall     = 1'b0;
    load_fire = 1'b0;
    unique case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        stall   = accept;
        if (accept) state_d = REQ;
      end
      REQ: begin
        stall = 1'b1;
        if (dmem_gnt_i) state_d = WAIT;
      end
      WAIT: begin
        stall = !dmem_rvalid_i;
        if (dmem_rvalid_i) begin
          state_d   = IDLE;
          load_fire = !we_q && !abort_q && !flush_i;
        end
      end
      default: state_d = IDLE;
    endcase
    // A killed op lets the pipeline run; only a younger mem op has to wait for IDLE.
    if (state_q != IDLE) begin
      if (abort_q || flush_i) stall = abort_q && mem_op && !flush_i;
      abort_d = (abort_q || flush_i) && (state_d != IDLE);
    end
  end

  // FSM state and abort flag.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      abort_q <= abort_d;
    end
  end

  // Request fields captured on accept and held until the next accept.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      size_q     <= SZ_BYTE;
      unsigned_q <= 1'b0;
      offset_q   <= 2'b00;
    end else if (accept) begin
      addr_q     <= {m_alu_data_i[ADDR_W-1:2], 2'b00};
      be_q       <= al_be;
      wdata_q    <= al_wdata;
      we_q       <= (m_mem_op_i == MEM_STORE);
      size_q     <= m_mem_size_i;
      unsigned_q <= m_mem_unsigned_i;
      offset_q   <= m_alu_data_i[1:0];
    end
  end

  // One-cycle status pulses and the load result for W.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      misalign_q   <= 1'b0;
      load_valid_q <= 1'b0;
      load_data_q  <= '0;
    end else begin
      misalign_q   <= (state_q == IDLE) && mem_op && misaligned && !flush_i;
      load_valid_q <= load_fire;
      if (load_fire) load_data_q <= al_load;
    end
  end

  assign dmem_req_o     = (state_q == REQ);
  assign dmem_we_o      = we_q;
  assign dmem_addr_o    = addr_q;
  assign dmem_be_o      = be_q;
  assign dmem_wdata_o   = wdata_q;
  assign stall_o        = stall;
  assign misalign_o     = misalign_q;
  assign w_load_valid_o = load_valid_q;
  assign w_load_data_o  = load_data_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench for lsu_mem_stage: directed cases plus randomized ops against a
// word-array memory model and arithmetic lane/extension reference.
module tb_lsu_mem_stage;
  import proc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m_valid;
  mem_op_t     m_op;
  mem_size_t   m_size;
  logic        m_uns;
  logic [31:0] m_addr;
  logic [31:0] m_sd;
  logic        flush;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        stall, misalign, lv;
  logic [31:0] ld;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [31:0] mem [int unsigned];

  always #5 clk = ~clk;

  lsu_mem_stage #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .m_valid_i        (m_valid),
    .m_mem_op_i       (m_op),
    .m_mem_size_i     (m_size),
    .m_mem_unsigned_i (m_uns),
    .m_alu_data_i     (m_addr),
    .m_store_data_i   (m_sd),
    .flush_i          (flush),
    .dmem_req_o       (dmem_req),
    .dmem_we_o        (dmem_we),
    .dmem_addr_o      (dmem_addr),
    .dmem_be_o        (dmem_be),
    .dmem_wdata_o     (dmem_wdata),
    .dmem_gnt_i       (dmem_gnt),
    .dmem_rvalid_i    (dmem_rvalid),
    .dmem_rdata_i     (dmem_rdata),
    .stall_o          (stall),
    .misalign_o       (misalign),
    .w_load_valid_o   (lv),
    .w_load_data_o    (ld)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_load(int sz, bit uns, int off, logic [31:0] w);
    longint v;
    v = longint'(w >> (8 * off));
    if (sz == 0) begin
      v = v % 256;
      if (!uns && v >= 128) v = v - 256;
    end else if (sz == 1) begin
      v = v % 65536;
      if (!uns && v >= 32768) v = v - 65536;
    end
    return v[31:0];
  endfunction

  function automatic logic [3:0] ref_be(int sz, int off);
    if (sz == 0) return 4'(1 << off);
    if (sz == 1) return 4'(3 << off);
    return 4'hF;
  endfunction

  function automatic logic [31:0] ref_wdata(int sz, logic [31:0] d);
    if (sz == 0) return (d & 32'hFF) * 32'h0101_0101;
    if (sz == 1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  // One op through M; memory response after gdly withheld-gnt cycles and rdly cycles past gnt.
  task automatic run_op(input logic [1:0] op, input logic [1:0] sz, input bit uns,
                        input logic [31:0] addr, input logic [31:0] sd, input int gdly,
                        input int rdly, input bit do_flush);
    bit          mis;
    int          off;
    int unsigned idx;
    logic [3:0]  ebe;
    logic [31:0] ewd, word;
    off = int'(addr % 4);
    idx = addr / 4;
    mis = (sz == 2'd1 && (off % 2) == 1) || (sz == 2'd2 && off != 0);
    m_valid = 1'b1; m_op = mem_op_t'(op); m_size = mem_size_t'(sz);
    m_uns = uns; m_addr = addr; m_sd = sd;
    #1;
    if (op == 2'd0) begin
      check("none_stall", stall, 0);
      cycle(); m_valid = 1'b0; #1;
      check("none_req", dmem_req, 0);
      return;
    end
    if (mis) begin
      check("mis_stall", stall, 0);
      cycle(); m_valid = 1'b0; #1;
      check("mis_req", dmem_req, 0);
      check("mis_pulse", misalign, 1);
      check("mis_lv", lv, 0);
      cycle(); #1;
      check("mis_clear", misalign, 0);
      return;
    end
    ebe = ref_be(int'(sz), off);
    ewd = ref_wdata(int'(sz), sd);
    check("idle_stall", stall, 1);
    check("idle_req", dmem_req, 0);
    cycle(); #1;
    for (int k = 0; k <= gdly; k++) begin
      check("req", dmem_req, 1);
      check("req_addr", dmem_addr, addr & 32'hFFFF_FFFC);
      check("req_be", dmem_be, 32'(ebe));
      check("req_we", dmem_we, (op == 2'd2) ? 1 : 0);
      if (op == 2'd2) check("req_wdata", dmem_wdata, ewd);
      check("req_stall", stall, 1);
      if (k == gdly) dmem_gnt = 1'b1;
      cycle(); dmem_gnt = 1'b0; #1;
    end
    if (do_flush) begin
      flush = 1'b1; #1;
      check("flush_stall", stall, 0);
      check("flush_req", dmem_req, 0);
      cycle(); flush = 1'b0;
      m_valid = 1'b1; m_op = MEM_LOAD; m_size = SZ_WORD; m_addr = 32'h0; #1;
      check("abort_hold", stall, 1);
      m_valid = 1'b0; #1;
      check("abort_free", stall, 0);
    end else begin
      for (int k = 1; k < rdly; k++) begin
        check("wait_req", dmem_req, 0);
        check("wait_stall", stall, 1);
        cycle(); #1;
      end
    end
    if (!mem.exists(idx)) mem[idx] = $urandom;
    word = mem[idx];
    dmem_rvalid = 1'b1; dmem_rdata = word; #1;
    check("rv_stall", stall, 0);
    if (op == 2'd2) begin
      for (int i = 0; i < 4; i++) if (ebe[i]) word[8*i +: 8] = ewd[8*i +: 8];
      mem[idx] = word;
    end
    cycle(); dmem_rvalid = 1'b0; dmem_rdata = $urandom; m_valid = 1'b0; #1;
    if (op == 2'd1 && !do_flush) begin
      check("lv", lv, 1);
      check("ld", ld, ref_load(int'(sz), uns, off, mem[idx]));
    end else begin
      check("lv_none", lv, 0);
    end
    cycle(); #1;
    check("lv_pulse", lv, 0);
    check("idle_req2", dmem_req, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; m_valid = 1'b0; m_op = MEM_NONE; m_size = SZ_BYTE; m_uns = 1'b0;
    m_addr = '0; m_sd = '0; flush = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    dmem_rdata = '0;
    #2;
    check("rst_req", dmem_req, 0);
    check("rst_we", dmem_we, 0);
    check("rst_addr", dmem_addr, 0);
    check("rst_be", 32'(dmem_be), 0);
    check("rst_wdata", dmem_wdata, 0);
    check("rst_stall", stall, 0);
    check("rst_mis", misalign, 0);
    check("rst_lv", lv, 0);
    check("rst_ld", ld, 0);
    #10 rst_n = 1'b1;
    cycle();

    // Directed cases.
    mem[32'h40] = 32'hDEAD_BEEF;
    run_op(2'd1, 2'd2, 0, 32'h100, 32'h0, 0, 1, 0);
    check("lw_value", ld, 32'hDEAD_BEEF);
    mem[32'h40] = 32'h8011_2233;
    run_op(2'd1, 2'd0, 0, 32'h103, 32'h0, 0, 1, 0);
    check("lb_value", ld, 32'hFFFF_FF80);
    run_op(2'd1, 2'd0, 1, 32'h103, 32'h0, 1, 2, 0);
    check("lbu_value", ld, 32'h0000_0080);
    run_op(2'd1, 2'd1, 0, 32'h102, 32'h0, 0, 1, 0);
    check("lh_value", ld, 32'hFFFF_8011);
    run_op(2'd2, 2'd1, 0, 32'h1002, 32'h0000_ABCD, 0, 1, 0);
    run_op(2'd1, 2'd2, 0, 32'h200, 32'h0, 5, 3, 0);
    run_op(2'd1, 2'd2, 0, 32'h101, 32'h0, 0, 1, 0);
    run_op(2'd2, 2'd1, 0, 32'h3, 32'h1234, 0, 1, 0);
    mem[32'h50] = 32'h1234_5678;
    run_op(2'd1, 2'd2, 0, 32'h140, 32'h0, 0, 1, 1);

    // Reset while a request is outstanding.
    m_valid = 1'b1; m_op = MEM_LOAD; m_size = SZ_WORD; m_addr = 32'h80; #1;
    cycle(); #1;
    check("pre_rst_req", dmem_req, 1);
    rst_n = 1'b0; m_valid = 1'b0; #1;
    check("rst_mid_req", dmem_req, 0);
    check("rst_mid_stall", stall, 0);
    #3 rst_n = 1'b1;
    cycle(); #1;
    check("post_rst_req", dmem_req, 0);
    run_op(2'd1, 2'd2, 0, 32'h80, 32'h0, 0, 1, 0);

    // Randomized ops over a small address window so loads see earlier stores.
    for (int i = 0; i < 60; i++) begin
      run_op(2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
             32'($urandom_range(0, 31)), $urandom, int'($urandom_range(0, 3)),
             int'($urandom_range(1, 3)), ($urandom_range(0, 7) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
